alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Single-issue sequencer for the 20-bit ALU: accepts one op, iterates shifts a bit per
// cycle, keeps the {S,C,Z} status register and parks in a sticky trap on illegal opcodes.
module alu_op_sequencer #(
    parameter int WIDTH = 20,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [AMT_W-1:0] req_amt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_wb,
    output logic             res_trap,
    output logic [2:0]       status,
    output logic             trap_mode,
    input  logic             trap_clr
);

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_NOT   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SHL   = 5'd5;
    localparam logic [4:0] OP_SHR   = 5'd6;
    localparam logic [4:0] OP_ROL   = 5'd7;
    localparam logic [4:0] OP_ROR   = 5'd8;
    localparam logic [4:0] OP_INC   = 5'd9;
    localparam logic [4:0] OP_DEC   = 5'd10;
    localparam logic [4:0] OP_ADD   = 5'd11;
    localparam logic [4:0] OP_ADC   = 5'd12;
    localparam logic [4:0] OP_SUB   = 5'd13;
    localparam logic [4:0] OP_SBC   = 5'd14;
    localparam logic [4:0] OP_CMP   = 5'd15;
    localparam logic [4:0] OP_LDSR  = 5'd16;
    localparam logic [4:0] OP_XORSR = 5'd17;

    localparam logic [AMT_W-1:0] ONE_CNT = {{(AMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE,
        ST_TRAP
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [4:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic             cin_reg;
    logic             amt_zero_reg;
    logic [WIDTH-1:0] res_data_reg;
    logic             res_wb_reg;
    logic             res_trap_reg;
    logic [2:0]       status_reg;

    logic             accept;
    logic             finish;
    logic             consume;
    logic             is_shift_req;
    logic             left_dir;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] res_calc;
    logic             c_calc;
    logic             wb_calc;
    logic             trap_calc;
    logic             flags_from_res;
    logic [2:0]       status_calc;

    assign req_ready = (state_reg == ST_IDLE);
    assign res_valid = (state_reg == ST_DONE);
    assign trap_mode = (state_reg == ST_TRAP);
    assign res_data  = res_data_reg;
    assign res_wb    = res_wb_reg;
    assign res_trap  = res_trap_reg;
    assign status    = status_reg;

    assign is_shift_req = (req_op >= OP_SHL) && (req_op <= OP_ROR);
    assign left_dir     = (op_reg == OP_SHL) || (op_reg == OP_ROL);
    assign step_c       = left_dir ? work_reg[WIDTH-1] : work_reg[0];

    // One-bit step of the working value; rotates feed the far-end bit back in.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            logic from_lo;
            logic from_hi;
            if (gi == 0) begin : g_lo_edge
                assign from_lo = (op_reg == OP_ROL) ? work_reg[WIDTH-1] : 1'b0;
            end else begin : g_lo_mid
                assign from_lo = work_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_hi_edge
                assign from_hi = (op_reg == OP_ROR) ? work_reg[0] : 1'b0;
            end else begin : g_hi_mid
                assign from_hi = work_reg[gi+1];
            end
            assign step_val[gi] = left_dir ? from_lo : from_hi;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        consume    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == ONE_CNT) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    consume    = 1'b1;
                    state_next = res_trap_reg ? ST_TRAP : ST_IDLE;
                end
            end
            ST_TRAP: begin
                if (trap_clr) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Result and flag computation; only sampled on the final EXEC edge.
    always_comb begin
        sum_ext        = '0;
        res_calc       = '0;
        c_calc         = 1'b0;
        wb_calc        = 1'b1;
        trap_calc      = 1'b0;
        flags_from_res = 1'b1;
        status_calc    = status_reg;
        case (op_reg)
            OP_NOP: begin
                wb_calc        = 1'b0;
                flags_from_res = 1'b0;
            end
            OP_NOT: res_calc = ~a_reg;
            OP_AND: res_calc = a_reg & b_reg;
            OP_OR:  res_calc = a_reg | b_reg;
            OP_XOR: res_calc = a_reg ^ b_reg;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                if (amt_zero_reg) begin
                    res_calc = a_reg;
                    c_calc   = status_reg[1];
                end else begin
                    res_calc = step_val;
                    c_calc   = step_c;
                end
            end
            OP_INC: begin
                sum_ext  = {1'b0, a_reg} + ONE_EXT;
                res_calc = sum_ext[WIDTH-1:0];
                c_calc   = sum_ext[WIDTH];
            end
            OP_DEC: begin
                sum_ext  = {1'b0, a_reg} - ONE_EXT;
                res_calc = sum_ext[WIDTH-1:0];
                c_calc   = sum_ext[WIDTH];
            end
            OP_ADD: begin
                sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
                res_calc = sum_ext[WIDTH-1:0];
                c_calc   = sum_ext[WIDTH];
            end
            OP_ADC: begin
                sum_ext  = {1'b0, a_reg} + {1'b0, b_reg} + {{WIDTH{1'b0}}, cin_reg};
                res_calc = sum_ext[WIDTH-1:0];
                c_calc   = sum_ext[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                sum_ext  = {1'b0, a_reg} - {1'b0, b_reg};
                res_calc = sum_ext[WIDTH-1:0];
                c_calc   = sum_ext[WIDTH];
                wb_calc  = (op_reg == OP_SUB);
            end
            OP_SBC: begin
                sum_ext  = {1'b0, a_reg} - {1'b0, b_reg} - {{WIDTH{1'b0}}, cin_reg};
                res_calc = sum_ext[WIDTH-1:0];
                c_calc   = sum_ext[WIDTH];
            end
            OP_LDSR: begin
                res_calc       = a_reg;
                wb_calc        = 1'b0;
                flags_from_res = 1'b0;
                status_calc    = a_reg[2:0];
            end
            OP_XORSR: begin
                res_calc       = a_reg;
                wb_calc        = 1'b0;
                flags_from_res = 1'b0;
                status_calc    = status_reg ^ a_reg[2:0];
            end
            default: begin
                wb_calc        = 1'b0;
                trap_calc      = 1'b1;
                flags_from_res = 1'b0;
            end
        endcase
        if (flags_from_res) begin
            status_calc = {res_calc[WIDTH-1], c_calc, (res_calc == '0)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            work_reg     <= '0;
            cnt_reg      <= '0;
            cin_reg      <= 1'b0;
            amt_zero_reg <= 1'b0;
            res_data_reg <= '0;
            res_wb_reg   <= 1'b0;
            res_trap_reg <= 1'b0;
            status_reg   <= '0;
        end else if (accept) begin
            op_reg       <= req_op;
            a_reg        <= req_a;
            b_reg        <= req_b;
            work_reg     <= req_a;
            cin_reg      <= status_reg[1];
            amt_zero_reg <= (req_amt == '0);
            cnt_reg      <= (is_shift_req && (req_amt != '0)) ? req_amt : ONE_CNT;
        end else if (state_reg == ST_EXEC) begin
            cnt_reg  <= cnt_reg - ONE_CNT;
            work_reg <= step_val;
            if (finish) begin
                res_data_reg <= res_calc;
                res_wb_reg   <= wb_calc;
                res_trap_reg <= trap_calc;
                status_reg   <= status_calc;
            end
        end else if (consume) begin
            // res_data stays as the last result; the qualifiers drop with res_valid.
            res_wb_reg   <= 1'b0;
            res_trap_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: transaction-level reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_alu_op_sequencer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic        trap_clr  = 1'b0;
    logic [4:0]  req_op    = '0;
    logic [19:0] req_a     = '0;
    logic [19:0] req_b     = '0;
    logic [4:0]  req_amt   = '0;
    logic        req_ready;
    logic        res_valid;
    logic        res_wb;
    logic        res_trap;
    logic        trap_mode;
    logic [19:0] res_data;
    logic [2:0]  status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(20), .AMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_amt   (req_amt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_wb    (res_wb),
        .res_trap  (res_trap),
        .status    (status),
        .trap_mode (trap_mode),
        .trap_clr  (trap_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [19:0] res;
        logic        wb;
        logic        trap;
        logic [2:0]  st;
        logic [5:0]  n;
    } exp_t;

    // Whole-operation result from plain arithmetic; shifts/rotates as single wide shifts.
    function automatic exp_t model(input logic [4:0] op, input logic [19:0] a, input logic [19:0] b,
                                   input logic [4:0] amt, input logic [2:0] st);
        exp_t e;
        longint unsigned mask, wa, wbv, cin, r, k, tmp;
        logic c, sr;
        mask = 64'hFFFFF;
        wa = longint'(a); wbv = longint'(b); cin = {63'd0, st[1]};
        r = 0; c = 1'b0; sr = 1'b0;
        e.wb = 1'b1; e.trap = 1'b0; e.n = 6'd1; e.st = st; e.res = '0;
        case (op)
            5'd0: begin e.wb = 1'b0; sr = 1'b1; end
            5'd1: r = ~wa & mask;
            5'd2: r = wa & wbv;
            5'd3: r = wa | wbv;
            5'd4: r = wa ^ wbv;
            5'd5, 5'd6, 5'd7, 5'd8: begin
                if (amt == 5'd0) begin
                    r = wa; c = st[1];
                end else begin
                    e.n = {1'b0, amt};
                    k = longint'(amt) % 64'd20;
                    case (op)
                        5'd5: begin tmp = wa << amt; r = tmp & mask; c = tmp[20]; end
                        5'd6: begin tmp = wa >> (amt - 5'd1); r = wa >> amt; c = tmp[0]; end
                        5'd7: begin r = ((wa << k) | (wa >> (64'd20 - k))) & mask; c = r[0]; end
                        default: begin r = ((wa >> k) | (wa << (64'd20 - k))) & mask; c = r[19]; end
                    endcase
                end
            end
            5'd9:  begin r = wa + 64'd1; c = r[20]; r = r & mask; end
            5'd10: begin c = (wa == 64'd0); r = (wa - 64'd1) & mask; end
            5'd11: begin r = wa + wbv; c = r[20]; r = r & mask; end
            5'd12: begin r = wa + wbv + cin; c = r[20]; r = r & mask; end
            5'd13, 5'd15: begin
                c = (wa < wbv); r = (wa - wbv) & mask;
                if (op == 5'd15) e.wb = 1'b0;
            end
            5'd14: begin c = (wa < wbv + cin); r = (wa - wbv - cin) & mask; end
            5'd16: begin r = wa; e.wb = 1'b0; sr = 1'b1; e.st = a[2:0]; end
            5'd17: begin r = wa; e.wb = 1'b0; sr = 1'b1; e.st = st ^ a[2:0]; end
            default: begin r = 0; e.wb = 1'b0; e.trap = 1'b1; sr = 1'b1; end
        endcase
        e.res = r[19:0];
        if (!sr) e.st = {r[19], c, (r[19:0] == 20'd0)};
        return e;
    endfunction

    // Reference: outstanding-transaction tracker with a latency countdown.
    exp_t       m_exp  = '0;
    exp_t       m_next;
    logic [2:0] m_st   = '0;
    logic       m_busy = 1'b0;
    logic       m_have = 1'b0;
    logic       m_trap = 1'b0;
    logic [5:0] m_left = '0;

    always_comb m_next = model(req_op, req_a, req_b, req_amt, m_st);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exp <= '0; m_st <= '0; m_busy <= 1'b0; m_have <= 1'b0; m_trap <= 1'b0; m_left <= '0;
        end else if (m_trap) begin
            if (trap_clr) m_trap <= 1'b0;
        end else if (m_have) begin
            if (res_ready) begin
                m_have <= 1'b0;
                m_trap <= m_exp.trap;
            end
        end else if (m_busy) begin
            if (m_left == 6'd1) begin
                m_busy <= 1'b0;
                m_have <= 1'b1;
                m_st   <= m_exp.st;
            end
            m_left <= m_left - 6'd1;
        end else if (req_valid) begin
            m_exp  <= m_next;
            m_left <= m_next.n;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_have && !m_trap));
        chk("res_valid", 32'(res_valid), 32'(m_have));
        chk("trap_mode", 32'(trap_mode), 32'(m_trap));
        chk("status", 32'(status), 32'(m_st));
        chk("res_wb", 32'(res_wb), 32'(m_have ? m_exp.wb : 1'b0));
        chk("res_trap", 32'(res_trap), 32'(m_have ? m_exp.trap : 1'b0));
        if (m_have) chk("res_data", 32'(res_data), 32'(m_exp.res));
    end

    logic [19:0] d;
    logic [2:0]  st;
    logic        wb;
    logic        tr;
    int          lat;

    task automatic run_op(input logic [4:0] op, input logic [19:0] a, input logic [19:0] b,
                          input logic [4:0] amt, input int hold,
                          output logic [19:0] od, output logic [2:0] ost, output logic owb,
                          output logic otr, output int olat);
        bit got;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_amt = amt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        olat = 0; got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (res_valid) got = 1;
            else begin
                @(posedge clk);
                olat++;
                @(negedge clk);
            end
        end
        if (!got) chk("res_valid_timeout", 32'(res_valid), 1);
        od = res_data; ost = status; owb = res_wb; otr = res_trap;
        $display("op=%0d a=%05h b=%05h amt=%0d -> data=%05h wb=%0b trap=%0b status=%03b lat=%0d",
                 op, a, b, amt, od, owb, otr, ost, olat);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_data", 32'(res_data), 32'(od));
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_status", 32'(status), 32'(ost));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_trap_mode", 32'(trap_mode), 0);
        chk("rst_res_data", 32'(res_data), 0);
        rst_n = 1'b1;

        // Add/carry chain
        run_op(5'd11, 20'hFFFFF, 20'h00001, 5'd0, 0, d, st, wb, tr, lat);
        chk("add_lat", lat, 1); chk("add_res", 32'(d), 'h0); chk("add_wb", 32'(wb), 1); chk("add_st", 32'(st), 'b011);
        run_op(5'd12, 20'h0, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        chk("adc_res", 32'(d), 'h1); chk("adc_st", 32'(st), 'b000);

        // Shifts, including zero count and counts at/over the width
        run_op(5'd5, 20'h80001, 20'h0, 5'd3, 0, d, st, wb, tr, lat);
        chk("shl3_lat", lat, 3); chk("shl3_res", 32'(d), 'h8); chk("shl3_st", 32'(st), 'b000);
        run_op(5'd16, 20'h00002, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        chk("ldsr_st", 32'(st), 'b010); chk("ldsr_wb", 32'(wb), 0); chk("ldsr_res", 32'(d), 'h2);
        run_op(5'd5, 20'h80001, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        chk("shl0_lat", lat, 1); chk("shl0_res", 32'(d), 'h80001); chk("shl0_st", 32'(st), 'b110);
        run_op(5'd6, 20'hABCDE, 20'h0, 5'd25, 0, d, st, wb, tr, lat);
        chk("shr25_lat", lat, 25); chk("shr25_res", 32'(d), 'h0); chk("shr25_st", 32'(st), 'b001);
        run_op(5'd7, 20'h80000, 20'h0, 5'd21, 0, d, st, wb, tr, lat);
        chk("rol21_lat", lat, 21); chk("rol21_res", 32'(d), 'h1); chk("rol21_st", 32'(st), 'b010);

        // Inc/dec/sub family
        run_op(5'd9, 20'hFFFFF, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        chk("inc_res", 32'(d), 'h0); chk("inc_st", 32'(st), 'b011);
        run_op(5'd10, 20'h0, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        chk("dec_res", 32'(d), 'hFFFFF); chk("dec_st", 32'(st), 'b110);
        run_op(5'd13, 20'h5, 20'h7, 5'd0, 0, d, st, wb, tr, lat);
        chk("sub_res", 32'(d), 'hFFFFE); chk("sub_st", 32'(st), 'b110);
        run_op(5'd14, 20'h5, 20'h4, 5'd0, 0, d, st, wb, tr, lat);
        chk("sbc_res", 32'(d), 'h0); chk("sbc_st", 32'(st), 'b001);
        run_op(5'd15, 20'h7, 20'h7, 5'd0, 0, d, st, wb, tr, lat);
        chk("cmp_wb", 32'(wb), 0); chk("cmp_res", 32'(d), 'h0); chk("cmp_st", 32'(st), 'b001);
        run_op(5'd17, 20'h7, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        chk("xorsr_st", 32'(st), 'b110); chk("xorsr_res", 32'(d), 'h7);

        // Result held under backpressure
        run_op(5'd4, 20'h12345, 20'h0F0F0, 5'd0, 10, d, st, wb, tr, lat);
        chk("xor_res", 32'(d), 'h1D3B5); chk("xor_st", 32'(st), 'b000);
        chk("ready_after_consume", 32'(req_ready), 1);
        run_op(5'd0, 20'h12345, 20'h1, 5'd0, 0, d, st, wb, tr, lat);
        chk("nop_res", 32'(d), 'h0); chk("nop_wb", 32'(wb), 0); chk("nop_st", 32'(st), 'b000);

        // Illegal opcode and trap mode
        run_op(5'd13, 20'h5, 20'h7, 5'd0, 0, d, st, wb, tr, lat);
        run_op(5'd20, 20'h1, 20'h2, 5'd0, 0, d, st, wb, tr, lat);
        chk("ill_lat", lat, 1); chk("ill_trap", 32'(tr), 1); chk("ill_wb", 32'(wb), 0);
        chk("ill_res", 32'(d), 'h0); chk("ill_st", 32'(st), 'b110);
        chk("trap_mode_set", 32'(trap_mode), 1);
        req_valid = 1'b1; req_op = 5'd11; req_a = 20'h1; req_b = 20'h1;
        repeat (4) begin
            @(negedge clk);
            chk("trap_ignores_req", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        trap_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        trap_clr = 1'b0;
        chk("trap_clr_mode", 32'(trap_mode), 0); chk("trap_clr_ready", 32'(req_ready), 1);
        run_op(5'd11, 20'h3, 20'h4, 5'd0, 0, d, st, wb, tr, lat);
        chk("post_trap_add", 32'(d), 'h7); chk("post_trap_st", 32'(st), 'b000);

        // Asynchronous reset in the middle of a long rotate
        run_op(5'd10, 20'h0, 20'h0, 5'd0, 0, d, st, wb, tr, lat);
        @(negedge clk);
        req_valid = 1'b1; req_op = 5'd8; req_a = 20'h12345; req_b = 20'h0; req_amt = 5'd15;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("ror_busy", 32'(req_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 1); chk("arst_res_valid", 32'(res_valid), 0);
        chk("arst_status", 32'(status), 0); chk("arst_res_data", 32'(res_data), 0);
        chk("arst_trap_mode", 32'(trap_mode), 0); chk("arst_res_wb", 32'(res_wb), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(req_ready), 1); chk("rel_status", 32'(status), 0);
        run_op(5'd11, 20'h1, 20'h1, 5'd0, 0, d, st, wb, tr, lat);
        chk("post_rst_add", 32'(d), 'h2);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
